if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction fetch stage for the RV32I core. It holds the PC, issues word fetches to instruction memory over a valid/ready request channel, and captures the returned word into an IF/ID output register. That register feeds decode and the immediate generator through a valid/ready handshake. Branch/jump redirects from execute flush in-flight and buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value of id_instr whenever the output register is empty or flushed (addi x0,x0,0).
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word-aligned fetch address (equals pc).
- imem_rsp_valid  in  1  response valid; always accepted, no backpressure.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  control-flow redirect from execute.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- id_valid  out  1  id_instr/id_pc hold a valid instruction.
- id_ready  in  1  decode consumes the output this cycle.
- id_instr  out  32  instruction to decode.
- id_pc  out  32  PC of id_instr.

## Operation
- States: IDLE, FETCH, WAIT. At most one outstanding request.
- IDLE: entered on reset. Moves to FETCH unconditionally after one cycle.
- FETCH:
  - imem_req_valid = slot_free, where slot_free = !id_valid || id_ready. This is combinational.
  - imem_req_addr = pc.
  - On handshake (valid && ready): pc <= pc + 4 (mod 2^32, wraps at 0xFFFF_FFFC), fetch_pc <= pc, state <= WAIT.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid with kill = 0: id_instr <= imem_rsp_data, id_pc <= fetch_pc, id_valid <= 1, state <= FETCH.
  - On imem_rsp_valid with kill = 1: discard the response, kill <= 0, state <= FETCH.
- Output slot:
  - An id_valid && id_ready handshake with no response loading the slot in the same cycle sets id_valid <= 0 and id_instr <= NOP_INSTR.
  - The issue rule guarantees the slot is free whenever a response arrives, so no skid buffer is needed.
- Redirect (highest priority, any state except IDLE):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - id_valid <= 0, id_instr <= NOP_INSTR. An id_ready handshake in the same cycle is void, and decode must treat that instruction as flushed.
  - In FETCH with a request handshake in the same cycle: state <= WAIT, kill <= 1. The stale request's response is dropped.
  - In FETCH without a handshake: stay in FETCH. The next request uses the new pc.
  - In WAIT without a response: kill <= 1, stay in WAIT.
  - In WAIT with a response in the same cycle: drop the response, kill <= 0, state <= FETCH.
  - In IDLE: pc is updated, and the state still moves to FETCH.
- Reset mid-operation: returns immediately to the reset values. A response arriving after reset is ignored (state is IDLE, then FETCH with no outstanding request).

## Timing
- Reset values:
  - state = IDLE, pc = RESET_PC, fetch_pc = 0, kill = 0.
  - id_valid = 0, id_instr = NOP_INSTR, id_pc = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
- First request is asserted the second cycle after rst_n deasserts.
- The earliest response is one cycle after the request handshake. id_valid rises on the edge that samples imem_rsp_valid.
- Peak throughput: one instruction per 2 cycles with zero-latency memory and id_ready held at 1.
- Request stability: while imem_req_valid = 1 and imem_req_ready = 0, imem_req_addr stays constant unless a redirect occurs. A redirect may change the address; the request is then for the new pc.
- id_instr/id_pc stay stable while id_valid = 1 and id_ready = 0, unless a redirect occurs.

## Test plan
- Reset, RESET_PC=0x100, memory returns responses after 1 cycle, id_ready=1:
  - requests go out at 0x100, 0x104, 0x108, one per 2 cycles;
  - id_pc follows the same sequence, with id_instr matching the memory contents.
- Hold id_ready=0 for 5 cycles after the first id_valid:
  - id_instr/id_pc stay constant;
  - imem_req_valid stays 0;
  - fetching resumes at +4 once id_ready=1.
- Hold imem_req_ready=0 for 3 cycles:
  - imem_req_valid stays 1 with a constant address;
  - pc advances only after the handshake.
- Redirect to 0x2003 in WAIT, with the response 2 cycles later:
  - the response is dropped, id_valid stays 0;
  - the next request address is 0x2000.
- Redirect to 0x400 in the same cycle as imem_rsp_valid and id_ready:
  - id_valid goes to 0 and the response is discarded;
  - the next request is to 0x400, with id_pc=0x400 after its response.
- pc=0xFFFF_FFFC fetch:
  - the next request address wraps to 0x0000_0000.
- Assert rst_n=0 while in WAIT:
  - all outputs return to their reset values asynchronously;
  - a response arriving after reset is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage for the RV32I core. Holds the PC, issues one word
// fetch at a time to instruction memory over a valid/ready request channel,
// and captures the returned word into the IF/ID output register that feeds
// decode through a valid/ready handshake. Redirects from execute flush the
// in-flight request and the buffered instruction.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   imem_req_*       fetch request channel (valid/ready, word address)
//   imem_rsp_*       fetch response (always accepted, no backpressure)
//   redirect_*       control-flow redirect from execute
//   id_*             IF/ID output register with valid/ready handshake
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;

    logic        slot_free;
    logic        req_hs;
    logic        rsp_hit;
    logic        rsp_load;
    logic [31:0] redirect_pc_aligned;

    // A request may only go out when the output slot is empty or is being
    // drained this cycle; that guarantees the slot is free when the single
    // outstanding response returns, so no skid buffer is needed.
    assign slot_free           = !id_valid_q || id_ready;
    assign req_hs              = imem_req_valid && imem_req_ready;
    // Responses outside WAIT belong to no request of ours (e.g. one issued
    // before a reset) and are ignored.
    assign rsp_hit             = (state_q == ST_WAIT) && imem_rsp_valid;
    assign rsp_load            = rsp_hit && !kill_q && !redirect_valid;
    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= 32'h0;
            kill_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            // A redirect in the handshake cycle still goes to WAIT: the stale
            // request is outstanding and its response must be swallowed.
            ST_FETCH: if (req_hs) state_d = ST_WAIT;
            // Any response ends WAIT, whether it is kept or dropped.
            ST_WAIT:  if (rsp_hit) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values: pc, kill flag and the IF/ID output register
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;

        if (req_hs) begin
            pc_d       = pc_q + 32'd4;   // wraps naturally at 0xFFFF_FFFC
            fetch_pc_d = pc_q;
        end

        if (rsp_hit) begin
            kill_d = 1'b0;
        end

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end

        if (rsp_load) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rsp_data;
            id_pc_d    = fetch_pc_q;
        end

        // Redirect overrides everything above: the buffered instruction is
        // flushed (voiding a same-cycle decode handshake) and the PC jumps.
        if (redirect_valid) begin
            pc_d       = redirect_pc_aligned;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            // A request is (or becomes) outstanding for the old path: mark
            // its response to be dropped. A response arriving in this very
            // cycle is already discarded by rsp_load, so kill stays cleared.
            if (req_hs || (state_q == ST_WAIT && !rsp_hit)) begin
                kill_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req_valid = (state_q == ST_FETCH) && slot_free;
        imem_req_addr  = pc_q;
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. The bench plays instruction memory
// (one outstanding request, configurable response latency, contents given by
// a salted hash of the address) and keeps a program-order model: consumed
// instructions must come out at consecutive PCs, restarting at the aligned
// target of every redirect, and requests must walk the same sequence.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    if_fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---- memory / program-order model ----
    logic [31:0] salt;
    bit          outstanding;
    logic [31:0] out_addr;
    int          cnt;
    int          mem_lat;
    bit          force_rsp;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_addr;
    bit          idle_pending;
    int          cyc;
    int          delivered;

    // history for the stability checks
    bit          prev_redir;
    bit          prev_req_stall;
    logic [31:0] prev_req_addr;
    bit          prev_id_hold;
    logic [31:0] prev_id_pc;
    logic [31:0] prev_id_instr;

    // per-step samples
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [31:0] s_id_instr;
    bit          s_req_hs;
    bit          s_id_hs;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic reset_model();
        outstanding    = 1'b0;
        cnt            = 0;
        force_rsp      = 1'b0;
        exp_pc         = RST_PC;
        exp_req_addr   = RST_PC;
        idle_pending   = 1'b1;
        prev_redir     = 1'b0;
        prev_req_stall = 1'b0;
        prev_id_hold   = 1'b0;
    endtask

    // One clock cycle. Called just after a falling edge: drives inputs,
    // samples the settled outputs 1 ns later, checks them against the model,
    // then advances through the rising edge to the next falling edge.
    task automatic step(input bit req_rdy, input bit id_rdy,
                        input bit redir, input logic [31:0] rpc);
        bit rsp_now;
        bit exp_rv;
        rsp_now        = outstanding && (cnt == 0);
        imem_rsp_valid = rsp_now || force_rsp;
        imem_rsp_data  = rsp_now ? mem_word(out_addr) : $urandom;
        imem_req_ready = req_rdy;
        id_ready       = id_rdy;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_instr  = id_instr;

        // A request is allowed only with nothing outstanding, outside the
        // post-reset idle cycle, and when the output slot is or becomes free.
        exp_rv = !outstanding && !idle_pending && (!s_id_valid || id_rdy);
        n_checks++;
        if (s_req_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, s_req_valid, exp_rv);
        end
        if (s_id_valid === 1'b0) begin
            n_checks++;
            if (s_id_instr !== NOP) begin
                n_fail++;
                $display("FAIL empty_instr cyc=%0d: got %h expected %h", cyc, s_id_instr, NOP);
            end
        end
        if (prev_redir) begin
            n_checks++;
            if (s_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_valid cyc=%0d: got %b expected 0", cyc, s_id_valid);
            end
        end
        if (prev_req_stall) begin
            n_checks++;
            if (s_req_valid !== 1'b1 || s_req_addr !== prev_req_addr) begin
                n_fail++;
                $display("FAIL req_stable cyc=%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                         cyc, s_req_valid, s_req_addr, prev_req_addr);
            end
        end
        if (prev_id_hold) begin
            n_checks++;
            if (s_id_valid !== 1'b1 || s_id_pc !== prev_id_pc || s_id_instr !== prev_id_instr) begin
                n_fail++;
                $display("FAIL id_stable cyc=%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         cyc, s_id_valid, s_id_pc, s_id_instr, prev_id_pc, prev_id_instr);
            end
        end

        s_req_hs = s_req_valid && req_rdy;
        if (s_req_hs) begin
            n_checks++;
            if (s_req_addr !== exp_req_addr) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, s_req_addr, exp_req_addr);
            end
        end

        s_id_hs = s_id_valid && id_rdy && !redir;
        if (s_id_hs) begin
            n_checks++;
            if (s_id_pc !== exp_pc || s_id_instr !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL id_out cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                         cyc, s_id_pc, s_id_instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end

        if (redir) begin
            exp_pc       = {rpc[31:2], 2'b00};
            exp_req_addr = {rpc[31:2], 2'b00};
        end else if (s_req_hs) begin
            exp_req_addr = exp_req_addr + 32'd4;
        end

        prev_redir     = redir;
        prev_req_stall = s_req_valid && !req_rdy && !redir;
        prev_req_addr  = s_req_addr;
        prev_id_hold   = s_id_valid && !id_rdy && !redir;
        prev_id_pc     = s_id_pc;
        prev_id_instr  = s_id_instr;

        @(posedge clk);
        idle_pending = 1'b0;
        if (rsp_now) outstanding = 1'b0;
        else if (outstanding && cnt > 0) cnt--;
        if (s_req_hs) begin
            outstanding = 1'b1;
            out_addr    = s_req_addr;
            cnt         = mem_lat - 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle (away from any clock edge) and checks that
    // every output takes its reset value before the next edge.
    task automatic apply_reset();
        #2;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || id_valid !== 1'b0 ||
            id_instr !== NOP || id_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: got rv=%b ra=%h iv=%b ii=%h ip=%h expected rv=0 ra=%h iv=0 ii=%h ip=0",
                     imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, RST_PC, NOP);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_reset();
        apply_reset();
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle_req: got %b expected 0", s_req_valid);
        end
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h",
                     s_req_valid, s_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int target;
        int budget;
        int prev_c;
        bit have_prev;
        mem_lat   = 1;
        target    = delivered + 8;
        budget    = 0;
        have_prev = 1'b0;
        prev_c    = 0;
        while (delivered < target && budget < 60) begin
            int c;
            c = cyc;
            step(1, 1, 0, 32'h0);
            if (s_id_hs) begin
                if (have_prev) begin
                    n_checks++;
                    if (c - prev_c != 2) begin
                        n_fail++;
                        $display("FAIL stream_rate: got %0d cycles between instructions expected 2", c - prev_c);
                    end
                end
                have_prev = 1'b1;
                prev_c    = c;
            end
            budget++;
        end
        n_checks++;
        if (delivered < target) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d instructions expected %0d", delivered, target);
        end
    endtask

    task automatic test_stall_id();
        int budget;
        logic [31:0] held_pc;
        budget = 0;
        step(1, 0, 0, 32'h0);
        while (!s_id_valid && budget < 20) begin
            step(1, 0, 0, 32'h0);
            budget++;
        end
        held_pc = s_id_pc;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 32'h0);
            n_checks++;
            if (s_id_valid !== 1'b1 || s_id_pc !== held_pc || s_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL id_stall: got iv=%b pc=%h rv=%b expected iv=1 pc=%h rv=0",
                         s_id_valid, s_id_pc, s_req_valid, held_pc);
            end
        end
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== held_pc + 32'd4) begin
            n_fail++;
            $display("FAIL resume_addr: got valid=%b addr=%h expected valid=1 addr=%h",
                     s_req_valid, s_req_addr, held_pc + 32'd4);
        end
    endtask

    task automatic test_req_stall();
        int budget;
        logic [31:0] a;
        budget = 0;
        step(0, 1, 0, 32'h0);
        while (!s_req_valid && budget < 20) begin
            step(0, 1, 0, 32'h0);
            budget++;
        end
        a = s_req_addr;
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 32'h0);
            n_checks++;
            if (s_req_valid !== 1'b1 || s_req_addr !== a) begin
                n_fail++;
                $display("FAIL req_stall: got valid=%b addr=%h expected valid=1 addr=%h",
                         s_req_valid, s_req_addr, a);
            end
        end
        step(1, 1, 0, 32'h0);
        budget = 0;
        step(1, 1, 0, 32'h0);
        while (!s_req_hs && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        n_checks++;
        if (s_req_addr !== a + 32'd4) begin
            n_fail++;
            $display("FAIL pc_after_hs: got %h expected %h", s_req_addr, a + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        int budget;
        mem_lat = 3;
        budget  = 0;
        while (!(outstanding && cnt == 2) && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        step(1, 1, 1, 32'h0000_2003);
        mem_lat = 1;
        budget  = 0;
        s_req_hs = 1'b0;
        while (!s_req_hs && budget < 20) begin
            step(1, 1, 0, 32'h0);
            n_checks++;
            if (s_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_wait_drop: got id_valid=%b expected 0", s_id_valid);
            end
            budget++;
        end
        n_checks++;
        if (!s_req_hs || s_req_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL redir_wait_addr: got hs=%b addr=%h expected hs=1 addr=00002000", s_req_hs, s_req_addr);
        end
    endtask

    task automatic test_redirect_rsp();
        int budget;
        mem_lat = 1;
        budget  = 0;
        while (!(outstanding && cnt == 0) && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        step(1, 1, 1, 32'h0000_0400);
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL redir_rsp_next: got iv=%b rv=%b addr=%h expected iv=0 rv=1 addr=00000400",
                     s_id_valid, s_req_valid, s_req_addr);
        end
        budget = 0;
        s_id_hs = 1'b0;
        while (!s_id_hs && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        n_checks++;
        if (!s_id_hs || s_id_pc !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL redir_rsp_pc: got hs=%b pc=%h expected hs=1 pc=00000400", s_id_hs, s_id_pc);
        end
    endtask

    task automatic test_wrap();
        int budget;
        logic [31:0] addrs [2];
        budget = 0;
        while ((outstanding || idle_pending) && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        // Stalled request, so the redirect lands in FETCH without a handshake.
        step(0, 1, 1, 32'hFFFF_FFFF);
        for (int k = 0; k < 2; k++) begin
            budget   = 0;
            s_req_hs = 1'b0;
            while (!s_req_hs && budget < 20) begin
                step(1, 1, 0, 32'h0);
                budget++;
            end
            addrs[k] = s_req_addr;
        end
        n_checks++;
        if (addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h,%h expected fffffffc,00000000", addrs[0], addrs[1]);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        mem_lat = 3;
        budget  = 0;
        while (!outstanding && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        apply_reset();
        mem_lat   = 1;
        // Stale response from the request issued before reset.
        force_rsp = 1'b1;
        step(1, 1, 0, 32'h0);
        force_rsp = 1'b0;
        n_checks++;
        if (s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_rsp_idle: got id_valid=%b expected 0", s_id_valid);
        end
        step(1, 1, 0, 32'h0);
        n_checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL post_reset_req: got iv=%b rv=%b addr=%h expected iv=0 rv=1 addr=%h",
                     s_id_valid, s_req_valid, s_req_addr, RST_PC);
        end
        budget  = 0;
        s_id_hs = 1'b0;
        while (!s_id_hs && budget < 20) begin
            step(1, 1, 0, 32'h0);
            budget++;
        end
        n_checks++;
        if (!s_id_hs || s_id_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL post_reset_pc: got hs=%b pc=%h expected hs=1 pc=%h", s_id_hs, s_id_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit rr;
            bit ir;
            bit rd;
            mem_lat = $urandom_range(1, 3);
            rr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 9) < 7);
            rd = !idle_pending && ($urandom_range(0, 19) == 0);
            step(rr, ir, rd, $urandom);
        end
        mem_lat = 1;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0);
    endtask

    initial begin
        salt           = $urandom;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        mem_lat        = 1;
        cyc            = 0;
        delivered      = 0;
        reset_model();
        @(negedge clk);

        test_reset();
        test_stream();
        test_stall_id();
        test_req_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
